hazard_ctrl: RTL and testbench

- Central pipeline hazard controller for the 5-stage PCPU.
- Drives the stall and flush controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers: it issues flush requests; those registers respond to them.
- Detects load-use hazards, taken-branch/jump redirects and multi-cycle EX operations (mul/div).
- Sequences multi-cycle stalls with an internal FSM and down-counter.

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, redirect flush and multi-cycle EX stall sequencing.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_use_rs1,
    input  logic       ID_use_rs2,
    input  logic [4:0] EX_rd,
    input  logic       EX_MemRead,
    input  logic       EX_mc_start,
    input  logic       EX_redirect,
    output logic       PC_stall,
    output logic       IF_ID_stall,
    output logic       IF_ID_flush,
    output logic       ID_EX_stall,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
`ifdef HAZARD_PERF_EN
    output logic       mc_busy,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`else
    output logic       mc_busy
`endif
);

    typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MC_LOAD     = CNT_W'(MC_LAT - 2);
    localparam bit               MC_HAS_BUSY = (MC_LAT > 2);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;

    assign load_use = EX_MemRead && (EX_rd != 5'd0) &&
                      ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                       (ID_use_rs2 && (ID_rs2 == EX_rd)));

    // Counter holds the busy cycles still to go, including the current one,
    // so it is back at 0 when the FSM returns to RUN.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        PC_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_stall  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        mc_busy      = 1'b0;
        if (Rst_n) begin
            case (state)
                RUN: begin
                    if (EX_redirect) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (EX_mc_start) begin
                        PC_stall     = 1'b1;
                        IF_ID_stall  = 1'b1;
                        ID_EX_stall  = 1'b1;
                        EX_MEM_flush = 1'b1;
                        if (MC_HAS_BUSY) begin
                            state_nxt = MC_BUSY;
                            cnt_nxt   = MC_LOAD;
                        end
                    end else if (load_use) begin
                        PC_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                    end
                end
                MC_BUSY: begin
                    mc_busy      = 1'b1;
                    PC_stall     = 1'b1;
                    IF_ID_stall  = 1'b1;
                    ID_EX_stall  = 1'b1;
                    EX_MEM_flush = 1'b1;
                    cnt_nxt      = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (PC_stall) begin
                perf_stall_cnt <= sat_inc(perf_stall_cnt);
            end
            if (IF_ID_flush || ID_EX_flush) begin
                perf_flush_cnt <= sat_inc(perf_flush_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: behavioural model checked every cycle plus directed literal vectors.
module tb_hazard_ctrl;

    localparam int MC_LAT = 4;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_MemRead, EX_mc_start, EX_redirect;
    logic       PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush, mc_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int mc_left  = 0;

    hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(3)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_mc_start(EX_mc_start), .EX_redirect(EX_redirect),
        .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
`ifdef HAZARD_PERF_EN
        .mc_busy(mc_busy), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
        .mc_busy(mc_busy)
`endif
    );

    always #5 Clk = ~Clk;

    // {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush, mc_busy}
    localparam logic [6:0] V_IDLE  = 7'b000_0000;
    localparam logic [6:0] V_LU    = 7'b110_0100;
    localparam logic [6:0] V_REDIR = 7'b001_0100;
    localparam logic [6:0] V_START = 7'b110_1010;
    localparam logic [6:0] V_BUSY  = 7'b110_1011;

    logic [6:0] dut_v;
    assign dut_v = {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_flush, mc_busy};

    function automatic logic [6:0] model_out();
        logic lu;
        lu = EX_MemRead && (EX_rd != 0) &&
             ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
        if (!Rst_n)           return V_IDLE;
        else if (mc_left > 0) return V_BUSY;
        else if (EX_redirect) return V_REDIR;
        else if (EX_mc_start) return V_START;
        else if (lu)          return V_LU;
        else                  return V_IDLE;
    endfunction

    // mc_left = busy cycles still owed after the start cycle of a multi-cycle op
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                            mc_left <= 0;
        else if (mc_left > 0)                  mc_left <= mc_left - 1;
        else if (!EX_redirect && EX_mc_start)  mc_left <= MC_LAT - 2;
    end

    always @(negedge Clk) begin
        logic [6:0] e;
        e = model_out();
        checks++;
        if (dut_v !== e) begin
            failures++;
            $display("FAIL model t=%0t got=%b exp=%b", $time, dut_v, e);
        end
    end

    task automatic drive(input logic red, input logic mcs, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2);
        EX_redirect = red; EX_mc_start = mcs; EX_MemRead = mr; EX_rd = rd;
        ID_rs1 = rs1; ID_rs2 = rs2; ID_use_rs1 = u1; ID_use_rs2 = u2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string name, input logic [6:0] exp);
        @(negedge Clk);
        checks++;
        if (dut_v !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, dut_v, exp);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(1, 1, 1, 5, 5, 5, 1, 1);
        cyc("reset_forces_zero_a", V_IDLE);
        cyc("reset_forces_zero_b", V_IDLE);
        Rst_n = 1'b1;
        idle();
        cyc("after_reset_idle", V_IDLE);

        drive(0, 0, 1, 5, 0, 5, 0, 1);
        cyc("loaduse_rs2", V_LU);
        idle();
        cyc("loaduse_one_bubble", V_IDLE);
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        cyc("loaduse_rd0", V_IDLE);
        drive(0, 0, 1, 5, 0, 5, 0, 0);
        cyc("loaduse_rs2_unused", V_IDLE);
        drive(0, 0, 1, 7, 7, 2, 1, 0);
        cyc("loaduse_rs1", V_LU);
        drive(0, 0, 0, 7, 7, 2, 1, 0);
        cyc("no_load_no_hazard", V_IDLE);

        drive(1, 0, 1, 3, 3, 0, 1, 0);
        cyc("redirect_over_loaduse", V_REDIR);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        cyc("redirect_over_mc_start", V_REDIR);
        idle();
        cyc("no_busy_after_redirect", V_IDLE);

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cyc("mc_start", V_START);
        idle();
        cyc("mc_busy_1", V_BUSY);
        drive(1, 1, 1, 4, 4, 4, 1, 1);
        cyc("mc_busy_2_ignores_inputs", V_BUSY);
        idle();
        cyc("mc_done", V_IDLE);

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cyc("mc_start_r", V_START);
        idle();
        cyc("mc_busy_1_r", V_BUSY);
        Rst_n = 1'b0;
        cyc("reset_mid_busy", V_IDLE);
        cyc("reset_held", V_IDLE);
        Rst_n = 1'b1;
        cyc("idle_after_mid_reset", V_IDLE);

`ifdef HAZARD_PERF_EN
        Rst_n = 1'b0;
        cyc("perf_reset", V_IDLE);
        chk32("perf_stall_reset", perf_stall_cnt, 32'd0);
        chk32("perf_flush_reset", perf_flush_cnt, 32'd0);
        Rst_n = 1'b1;
        drive(0, 0, 1, 5, 0, 5, 0, 1);
        cyc("perf_lu", V_LU);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        cyc("perf_redir", V_REDIR);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cyc("perf_start", V_START);
        idle();
        cyc("perf_busy_1", V_BUSY);
        cyc("perf_busy_2", V_BUSY);
        cyc("perf_idle", V_IDLE);
        chk32("perf_stall_cnt", perf_stall_cnt, 32'd4);
        chk32("perf_flush_cnt", perf_flush_cnt, 32'd2);
`endif

        @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
